filter_streamer: RTL and testbench
==================================

FILTER_STREAMER -- requirements
Module: filter_streamer

Interface
REQ-001 SHALL have parameter NUM_ALLOC, default 220, meaning the number of filter_block inputs.
REQ-002 SHALL have parameter DATA_W, default 18, meaning the weight width.
REQ-003 SHALL have parameter CNT_W, default 13, meaning the filter length and counter width.
REQ-004 SHALL have parameter ADDR_W, default 16, meaning the memory address width.
REQ-005 SHALL have parameter RD_LAT, default 1, range 1..4, meaning the cycles from rd_en to valid rd_data.
REQ-006 SHALL have parameter FIFO_DEPTH, default 8, power of 2, >= RD_LAT+2, meaning the output buffer entries.
REQ-007 clk  in  1  clock; all logic on the rising edge.
REQ-008 rst  in  1  reset, synchronous, active-high.
REQ-009 start  in  1  one-cycle request to begin a round.
REQ-010 filter_base  in  ADDR_W  first weight address, sampled on accepted start.
REQ-011 filter_length  in  CNT_W  weights per pass, sampled on accepted start.
REQ-012 repeat_count  in  8  passes per round, sampled on accepted start.
REQ-013 filter_block  in  NUM_ALLOC  any bit high stalls output.
REQ-014 rd_en  out  1  memory read strobe.
REQ-015 rd_addr  out  ADDR_W  memory read address.
REQ-016 rd_data  in  DATA_W  memory data, valid RD_LAT cycles after rd_en.
REQ-017 out_valid  out  1  out_data, out_counter and out_pass are valid and consumed this cycle.
REQ-018 out_data  out  DATA_W  weight.
REQ-019 out_counter  out  CNT_W  weight index within the pass, 0..filter_length-1.
REQ-020 out_pass  out  8  pass index, 0..repeat_count-1.
REQ-021 busy  out  1  round in progress.
REQ-022 done  out  1  level; round complete, held until next accepted start or rst.

Function
REQ-023 SHALL implement states IDLE, ISSUE, DRAIN, DONE.
REQ-024 SHALL accept start only in IDLE or DONE; start in ISSUE or DRAIN SHALL be ignored.
REQ-025 Accepted start SHALL latch the inputs, clear done, set busy, zero the read index and pass, and enter ISSUE next cycle.
REQ-026 Accepted start with filter_length==0 or repeat_count==0 SHALL go to DONE next cycle with no reads and no outputs.
REQ-027 In ISSUE, rd_en SHALL be high only when outstanding reads plus FIFO occupancy < FIFO_DEPTH (credit rule); the FIFO SHALL never overflow.
REQ-028 rd_addr SHALL equal filter_base + read index, truncated to ADDR_W (wraps modulo 2^ADDR_W).
REQ-029 Each read SHALL carry its index and pass through an RD_LAT-deep tag pipeline; rd_data plus tags SHALL be written into the FIFO exactly RD_LAT cycles after rd_en.
REQ-030 After index filter_length-1 is read, index SHALL reset to 0 and pass SHALL increment; after the last index of pass repeat_count-1, state SHALL become DRAIN.
REQ-031 out_valid SHALL equal (FIFO not empty) AND NOT (|filter_block), combinationally; when out_valid is high, the FIFO head SHALL be popped at that edge.
REQ-032 Blocking SHALL never drop or duplicate a weight; reads continue while credits remain.
REQ-033 Simultaneous FIFO push and pop SHALL keep occupancy unchanged; a pop on an empty FIFO SHALL never occur.
REQ-034 Outputs SHALL appear in strict order (pass, counter) ascending.
REQ-035 DRAIN SHALL go to DONE in the cycle after the FIFO is empty and no reads are outstanding; DONE sets done=1 and busy=0.
REQ-036 out_data, out_counter and out_pass SHALL show the FIFO head and are don't-care when out_valid=0.

Reset
REQ-037 rst SHALL force IDLE, rd_en=0, out_valid=0, busy=0, done=0, index=0, pass=0, FIFO empty and tag pipeline cleared, with priority over start.
REQ-038 rst during ISSUE or DRAIN SHALL discard all in-flight reads; any rd_data returning afterwards SHALL be ignored.

Verification
REQ-039 Basic: RD_LAT=1, base=0x0100, length=4, repeat=1, no block -> rd_addr 0x0100..0x0103; out_counter 0,1,2,3; out_data matches memory; done rises and busy=0 in the following cycles.
REQ-040 Backpressure: length=16, filter_block[57]=1 for 10 cycles mid-stream -> out_valid=0 throughout; rd_en stops when FIFO plus outstanding equals 8; all 16 weights delivered in order afterwards.
REQ-041 Repeat and wrap: base=0xFFFE, length=3, repeat=2 -> addresses FFFE, FFFF, 0000 twice; out_pass 0,0,0,1,1,1.
REQ-042 Zero length: length=0, repeat=5, start -> no rd_en, no out_valid, done=1 after one cycle.
REQ-043 Latency sweep: RD_LAT=3, FIFO_DEPTH=8, random block at 50% -> scoreboard shows no loss, duplication or reordering, and the FIFO never overflows.
REQ-044 Mid-op reset and stray start: start during ISSUE is ignored; rst pulse at output 5 of 16 -> all outputs low next cycle, no outputs from returning stale data; a new start runs cleanly from counter 0.

Source files
------------

// File: rtl/filter_streamer_if.sv
// Bundle of the control, memory-read and output-stream signals of filter_streamer.
// The design side uses the slave modport; the environment (sequencer, memory, sink) uses master.
interface filter_streamer_if #(
  parameter int unsigned NUM_ALLOC = 220,
  parameter int unsigned DATA_W    = 18,
  parameter int unsigned CNT_W     = 13,
  parameter int unsigned ADDR_W    = 16
);
  logic                 start;
  logic [ADDR_W-1:0]    filter_base;
  logic [CNT_W-1:0]     filter_length;
  logic [7:0]           repeat_count;
  logic [NUM_ALLOC-1:0] filter_block;
  logic                 rd_en;
  logic [ADDR_W-1:0]    rd_addr;
  logic [DATA_W-1:0]    rd_data;
  logic                 out_valid;
  logic [DATA_W-1:0]    out_data;
  logic [CNT_W-1:0]     out_counter;
  logic [7:0]           out_pass;
  logic                 busy;
  logic                 done;

  modport master (
    output start, filter_base, filter_length, repeat_count, filter_block, rd_data,
    input  rd_en, rd_addr, out_valid, out_data, out_counter, out_pass, busy, done
  );

  modport slave (
    input  start, filter_base, filter_length, repeat_count, filter_block, rd_data,
    output rd_en, rd_addr, out_valid, out_data, out_counter, out_pass, busy, done
  );
endinterface

// File: rtl/filter_streamer.sv
// Streams filter weights from a fixed-latency memory through a credit-controlled FIFO,
// repeating the filter repeat_count times and stalling output while any filter_block bit is set.
module filter_streamer #(
  parameter int unsigned NUM_ALLOC  = 220,
  parameter int unsigned DATA_W     = 18,
  parameter int unsigned CNT_W      = 13,
  parameter int unsigned ADDR_W     = 16,
  parameter int unsigned RD_LAT     = 1,
  parameter int unsigned FIFO_DEPTH = 8
) (
  input logic             clk,
  input logic             rst,
  filter_streamer_if.slave bus
);

  localparam int unsigned PW = $clog2(FIFO_DEPTH);
  localparam int unsigned CW = PW + 1;
  localparam int unsigned SW = CW + 1;
  localparam int unsigned EW = DATA_W + CNT_W + 8;
  localparam logic [SW-1:0] DepthL = SW'(FIFO_DEPTH);

  typedef enum logic [1:0] {StIdle, StIssue, StDrain, StDone} state_e;

  state_e            state_q, state_d;
  logic [ADDR_W-1:0] base_q;
  logic [CNT_W-1:0]  len_q;
  logic [7:0]        rep_q;
  logic [CNT_W-1:0]  idx_q, idx_d;
  logic [7:0]        pass_q, pass_d;

  // Tags travel alongside each read so the FIFO entry knows its (pass, index).
  logic              tag_v_q    [RD_LAT];
  logic [CNT_W-1:0]  tag_idx_q  [RD_LAT];
  logic [7:0]        tag_pass_q [RD_LAT];

  logic [EW-1:0]     fifo_mem [FIFO_DEPTH];
  logic [PW-1:0]     wr_ptr_q, rd_ptr_q;
  logic [CW-1:0]     count_q, count_d;

  logic [NUM_ALLOC-1:0] block;
  logic              block_any;
  logic              fifo_empty;
  logic              push, pop;
  logic [SW-1:0]     outst;
  logic              credit_ok;
  logic              start_ok;
  logic              zero_req;
  logic              last_idx, last_pass;
  logic              rd_en;
  logic [EW-1:0]     head;

  assign block      = bus.filter_block;
  assign block_any  = |block;
  assign fifo_empty = (count_q == '0);
  assign pop        = !fifo_empty && !block_any;
  assign push       = tag_v_q[RD_LAT-1];
  assign start_ok   = bus.start && (state_q == StIdle || state_q == StDone);
  assign zero_req   = (bus.filter_length == '0) || (bus.repeat_count == '0);
  assign last_idx   = (idx_q == len_q - CNT_W'(1));
  assign last_pass  = (pass_q == rep_q - 8'd1);

  always_comb begin
    outst = '0;
    for (int i = 0; i < RD_LAT; i++) begin
      outst = outst + SW'(tag_v_q[i]);
    end
  end

  // Reserve a FIFO slot for every read in flight so returning data always has room.
  assign credit_ok = (outst + SW'(count_q)) < DepthL;

  always_comb begin
    state_d = state_q;
    idx_d   = idx_q;
    pass_d  = pass_q;
    rd_en   = 1'b0;
    unique case (state_q)
      StIdle, StDone: begin
        if (bus.start) begin
          state_d = zero_req ? StDone : StIssue;
          idx_d   = '0;
          pass_d  = '0;
        end
      end
      StIssue: begin
        if (credit_ok) begin
          rd_en = 1'b1;
          if (last_idx) begin
            idx_d = '0;
            if (last_pass) begin
              state_d = StDrain;
            end else begin
              pass_d = pass_q + 8'd1;
            end
          end else begin
            idx_d = idx_q + CNT_W'(1);
          end
        end
      end
      StDrain: begin
        if (fifo_empty && outst == '0) begin
          state_d = StDone;
        end
      end
      default: state_d = StIdle;
    endcase
  end

  always_comb begin
    count_d = count_q;
    unique case ({push, pop})
      2'b10:   count_d = count_q + CW'(1);
      2'b01:   count_d = count_q - CW'(1);
      default: count_d = count_q;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q  <= StIdle;
      base_q   <= '0;
      len_q    <= '0;
      rep_q    <= '0;
      idx_q    <= '0;
      pass_q   <= '0;
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
      count_q  <= '0;
      for (int i = 0; i < RD_LAT; i++) begin
        tag_v_q[i]    <= 1'b0;
        tag_idx_q[i]  <= '0;
        tag_pass_q[i] <= '0;
      end
    end else begin
      state_q <= state_d;
      idx_q   <= idx_d;
      pass_q  <= pass_d;
      if (start_ok) begin
        base_q <= bus.filter_base;
        len_q  <= bus.filter_length;
        rep_q  <= bus.repeat_count;
      end
      tag_v_q[0]    <= rd_en;
      tag_idx_q[0]  <= idx_q;
      tag_pass_q[0] <= pass_q;
      for (int i = 1; i < RD_LAT; i++) begin
        tag_v_q[i]    <= tag_v_q[i-1];
        tag_idx_q[i]  <= tag_idx_q[i-1];
        tag_pass_q[i] <= tag_pass_q[i-1];
      end
      if (push) wr_ptr_q <= wr_ptr_q + PW'(1);
      if (pop)  rd_ptr_q <= rd_ptr_q + PW'(1);
      count_q <= count_d;
    end
  end

  // Storage needs no reset; occupancy is tracked by count_q.
  always_ff @(posedge clk) begin
    if (push) begin
      fifo_mem[wr_ptr_q] <= {bus.rd_data, tag_idx_q[RD_LAT-1], tag_pass_q[RD_LAT-1]};
    end
  end

  assign head            = fifo_mem[rd_ptr_q];
  assign bus.out_valid   = pop;
  assign bus.out_data    = head[EW-1 -: DATA_W];
  assign bus.out_counter = head[8 +: CNT_W];
  assign bus.out_pass    = head[7:0];
  assign bus.rd_en       = rd_en;
  assign bus.rd_addr     = base_q + ADDR_W'(idx_q);
  assign bus.busy        = (state_q == StIssue) || (state_q == StDrain);
  assign bus.done        = (state_q == StDone);

endmodule

// File: tb/tb_filter_streamer.sv
// Directed bench for filter_streamer: one instance with RD_LAT=1 and one with RD_LAT=3,
// each fed by a behavioural memory and watched by a stream monitor.
module tb_filter_streamer;

  logic clk = 1'b0;
  logic rst;
  int   errors = 0;
  int   checks = 0;

  always #5 clk = ~clk;

  filter_streamer_if #(.NUM_ALLOC(220), .DATA_W(18), .CNT_W(13), .ADDR_W(16)) b1 ();
  filter_streamer_if #(.NUM_ALLOC(220), .DATA_W(18), .CNT_W(13), .ADDR_W(16)) b3 ();

  filter_streamer #(.RD_LAT(1), .FIFO_DEPTH(8)) dut1 (.clk(clk), .rst(rst), .bus(b1.slave));
  filter_streamer #(.RD_LAT(3), .FIFO_DEPTH(8)) dut3 (.clk(clk), .rst(rst), .bus(b3.slave));

  function automatic logic [17:0] mem_word(input logic [15:0] a);
    return {a[1:0], a ^ 16'hA55A};
  endfunction

  // Memories return the word for whatever address was presented RD_LAT cycles ago.
  logic [15:0] m1_a1, m3_a1, m3_a2, m3_a3;
  always @(posedge clk) begin
    m1_a1 <= b1.rd_addr;
    m3_a1 <= b3.rd_addr;
    m3_a2 <= m3_a1;
    m3_a3 <= m3_a2;
  end
  assign b1.rd_data = mem_word(m1_a1);
  assign b3.rd_data = mem_word(m3_a3);

  // Stream monitors; iss-del is exactly in-flight reads plus FIFO occupancy.
  int iss1 = 0, del1 = 0, viol1 = 0, blk1 = 0;
  int iss3 = 0, del3 = 0, viol3 = 0, blk3 = 0;
  logic [15:0] aq1[$], aq3[$];
  logic [17:0] dq1[$], dq3[$];
  logic [12:0] cq1[$], cq3[$];
  logic [7:0]  pq1[$], pq3[$];

  always @(negedge clk) begin
    #2;
    if (rst) begin
      iss1 = 0; del1 = 0; iss3 = 0; del3 = 0;
    end else begin
      if (b1.rd_en) begin
        if (iss1 - del1 >= 8) viol1++;
        aq1.push_back(b1.rd_addr); iss1++;
      end
      if (b1.out_valid) begin
        if (|b1.filter_block) blk1++;
        dq1.push_back(b1.out_data); cq1.push_back(b1.out_counter); pq1.push_back(b1.out_pass);
        del1++;
      end
      if (b3.rd_en) begin
        if (iss3 - del3 >= 8) viol3++;
        aq3.push_back(b3.rd_addr); iss3++;
      end
      if (b3.out_valid) begin
        if (|b3.filter_block) blk3++;
        dq3.push_back(b3.out_data); cq3.push_back(b3.out_counter); pq3.push_back(b3.out_pass);
        del3++;
      end
    end
  end

  task automatic do_reset();
    @(negedge clk); rst = 1'b1;
    repeat (2) @(negedge clk);
    rst = 1'b0;
  endtask

  task automatic start1(input logic [15:0] base, input logic [12:0] len, input logic [7:0] rep);
    @(negedge clk);
    b1.start = 1'b1; b1.filter_base = base; b1.filter_length = len; b1.repeat_count = rep;
    @(negedge clk);
    b1.start = 1'b0;
  endtask

  task automatic wait_done1(input int budget, output bit ok);
    ok = 1'b0;
    for (int n = 0; n < budget; n++) begin
      @(negedge clk); #1;
      if (b1.done === 1'b1) begin ok = 1'b1; break; end
    end
  endtask

  task automatic test_reset();
    do_reset(); #1;
    checks++; if (b1.rd_en !== 1'b0) begin errors++; $display("FAIL reset_rd_en: got %b want 0", b1.rd_en); end
    checks++; if (b1.out_valid !== 1'b0) begin errors++; $display("FAIL reset_out_valid: got %b want 0", b1.out_valid); end
    checks++; if (b1.busy !== 1'b0) begin errors++; $display("FAIL reset_busy: got %b want 0", b1.busy); end
    checks++; if (b1.done !== 1'b0) begin errors++; $display("FAIL reset_done: got %b want 0", b1.done); end
    checks++; if (b3.busy !== 1'b0 || b3.done !== 1'b0) begin
      errors++; $display("FAIL reset_b3: got busy=%b done=%b want 0 0", b3.busy, b3.done); end
  endtask

  task automatic test_basic();
    int a0, o0; bit ok;
    a0 = aq1.size(); o0 = dq1.size();
    start1(16'h0100, 13'd4, 8'd1); #1;
    checks++; if (b1.busy !== 1'b1 || b1.done !== 1'b0) begin
      errors++; $display("FAIL basic_busy: got busy=%b done=%b want 1 0", b1.busy, b1.done); end
    wait_done1(100, ok);
    checks++; if (!ok) begin errors++; $display("FAIL basic_done_timeout: got done=0 want 1"); end
    checks++; if (b1.busy !== 1'b0) begin errors++; $display("FAIL basic_busy_end: got %b want 0", b1.busy); end
    checks++; if (aq1.size() - a0 != 4 || dq1.size() - o0 != 4) begin
      errors++; $display("FAIL basic_count: got reads=%0d outs=%0d want 4 4", aq1.size() - a0, dq1.size() - o0); end
    for (int i = 0; i < 4 && a0 + i < aq1.size() && o0 + i < dq1.size(); i++) begin
      checks++; if (aq1[a0+i] !== 16'h0100 + 16'(i)) begin
        errors++; $display("FAIL basic_addr%0d: got %h want %h", i, aq1[a0+i], 16'h0100 + 16'(i)); end
      checks++; if (cq1[o0+i] !== 13'(i) || pq1[o0+i] !== 8'd0 || dq1[o0+i] !== mem_word(16'h0100 + 16'(i))) begin
        errors++; $display("FAIL basic_out%0d: got cnt=%0d pass=%0d data=%h want %0d 0 %h",
                           i, cq1[o0+i], pq1[o0+i], dq1[o0+i], i, mem_word(16'h0100 + 16'(i))); end
    end
  endtask

  task automatic test_backpressure();
    int o0, d0, n, bad, pend; logic rd_last; bit ok;
    o0 = dq1.size(); d0 = del1; bad = 0; pend = 0; rd_last = 1'bx;
    start1(16'h0200, 13'd16, 8'd1);
    n = 0;
    while (del1 - d0 < 3 && n < 50) begin @(negedge clk); n++; end
    for (int c = 0; c < 10; c++) begin
      if (c != 0) @(negedge clk);
      b1.filter_block[57] = 1'b1; #1;
      if (b1.out_valid !== 1'b0) bad++;
      if (c == 9) begin rd_last = b1.rd_en; pend = iss1 - del1; end
    end
    @(negedge clk); b1.filter_block = '0;
    checks++; if (bad != 0) begin errors++; $display("FAIL bp_valid_blocked: got %0d valid cycles want 0", bad); end
    checks++; if (rd_last !== 1'b0) begin errors++; $display("FAIL bp_rd_en_stall: got %b want 0", rd_last); end
    checks++; if (pend != 8) begin errors++; $display("FAIL bp_credit_full: got %0d want 8", pend); end
    wait_done1(200, ok);
    checks++; if (!ok) begin errors++; $display("FAIL bp_done_timeout: got done=0 want 1"); end
    checks++; if (dq1.size() - o0 != 16) begin errors++; $display("FAIL bp_count: got %0d want 16", dq1.size() - o0); end
    for (int i = 0; i < 16 && o0 + i < dq1.size(); i++) begin
      checks++; if (cq1[o0+i] !== 13'(i) || dq1[o0+i] !== mem_word(16'h0200 + 16'(i))) begin
        errors++; $display("FAIL bp_out%0d: got cnt=%0d data=%h want %0d %h",
                           i, cq1[o0+i], dq1[o0+i], i, mem_word(16'h0200 + 16'(i))); end
    end
    checks++; if (viol1 != 0) begin errors++; $display("FAIL bp_overflow: got %0d credit violations want 0", viol1); end
  endtask

  task automatic test_wrap();
    int a0, o0; bit ok; logic [15:0] ea; logic [15:0] addrs [3];
    addrs[0] = 16'hFFFE; addrs[1] = 16'hFFFF; addrs[2] = 16'h0000;
    a0 = aq1.size(); o0 = dq1.size();
    start1(16'hFFFE, 13'd3, 8'd2);
    wait_done1(100, ok);
    checks++; if (!ok) begin errors++; $display("FAIL wrap_done_timeout: got done=0 want 1"); end
    checks++; if (aq1.size() - a0 != 6 || dq1.size() - o0 != 6) begin
      errors++; $display("FAIL wrap_count: got reads=%0d outs=%0d want 6 6", aq1.size() - a0, dq1.size() - o0); end
    for (int i = 0; i < 6 && a0 + i < aq1.size() && o0 + i < dq1.size(); i++) begin
      ea = addrs[i % 3];
      checks++; if (aq1[a0+i] !== ea) begin errors++; $display("FAIL wrap_addr%0d: got %h want %h", i, aq1[a0+i], ea); end
      checks++; if (pq1[o0+i] !== 8'(i / 3) || cq1[o0+i] !== 13'(i % 3) || dq1[o0+i] !== mem_word(ea)) begin
        errors++; $display("FAIL wrap_out%0d: got pass=%0d cnt=%0d data=%h want %0d %0d %h",
                           i, pq1[o0+i], cq1[o0+i], dq1[o0+i], i / 3, i % 3, mem_word(ea)); end
    end
  endtask

  task automatic test_zero_len();
    int a0, o0;
    do_reset();
    a0 = aq1.size(); o0 = dq1.size();
    start1(16'h0500, 13'd0, 8'd5); #1;
    checks++; if (b1.done !== 1'b1 || b1.busy !== 1'b0) begin
      errors++; $display("FAIL zero_done: got done=%b busy=%b want 1 0", b1.done, b1.busy); end
    repeat (4) @(negedge clk);
    checks++; if (aq1.size() != a0 || dq1.size() != o0) begin
      errors++; $display("FAIL zero_activity: got reads=%0d outs=%0d want 0 0", aq1.size() - a0, dq1.size() - o0); end
  endtask

  task automatic test_stray_and_reset();
    int o0, d0, n, oa, aa; bit ok;
    o0 = dq1.size(); d0 = del1;
    start1(16'h0300, 13'd16, 8'd1);
    @(negedge clk);
    b1.start = 1'b1; b1.filter_base = 16'h0800; b1.filter_length = 13'd2; b1.repeat_count = 8'd1;
    @(negedge clk); b1.start = 1'b0;
    n = 0;
    while (del1 - d0 < 5 && n < 60) begin @(negedge clk); n++; end
    rst = 1'b1;
    @(negedge clk); rst = 1'b0; #1;
    checks++; if (b1.rd_en !== 1'b0 || b1.out_valid !== 1'b0) begin
      errors++; $display("FAIL mid_rst_outputs: got rd_en=%b out_valid=%b want 0 0", b1.rd_en, b1.out_valid); end
    checks++; if (b1.busy !== 1'b0 || b1.done !== 1'b0) begin
      errors++; $display("FAIL mid_rst_status: got busy=%b done=%b want 0 0", b1.busy, b1.done); end
    checks++; if (dq1.size() - o0 != 5) begin errors++; $display("FAIL mid_rst_prefix: got %0d want 5", dq1.size() - o0); end
    for (int i = 0; i < 5 && o0 + i < dq1.size(); i++) begin
      checks++; if (cq1[o0+i] !== 13'(i) || dq1[o0+i] !== mem_word(16'h0300 + 16'(i))) begin
        errors++; $display("FAIL stray_out%0d: got cnt=%0d data=%h want %0d %h",
                           i, cq1[o0+i], dq1[o0+i], i, mem_word(16'h0300 + 16'(i))); end
    end
    oa = dq1.size(); aa = aq1.size();
    repeat (6) @(negedge clk);
    checks++; if (dq1.size() != oa || aq1.size() != aa) begin
      errors++; $display("FAIL stale_outputs: got outs=%0d reads=%0d want 0 0", dq1.size() - oa, aq1.size() - aa); end
    start1(16'h0400, 13'd4, 8'd1);
    wait_done1(100, ok);
    checks++; if (!ok || dq1.size() - oa != 4) begin
      errors++; $display("FAIL restart_count: got done=%b outs=%0d want 1 4", ok, dq1.size() - oa); end
    for (int i = 0; i < 4 && oa + i < dq1.size(); i++) begin
      checks++; if (cq1[oa+i] !== 13'(i) || pq1[oa+i] !== 8'd0 || dq1[oa+i] !== mem_word(16'h0400 + 16'(i))) begin
        errors++; $display("FAIL restart_out%0d: got cnt=%0d pass=%0d data=%h want %0d 0 %h",
                           i, cq1[oa+i], pq1[oa+i], dq1[oa+i], i, mem_word(16'h0400 + 16'(i))); end
    end
  endtask

  task automatic test_latency3();
    int o0, a0, bad; bit ok; logic [15:0] ea;
    o0 = dq3.size(); a0 = aq3.size(); bad = 0; ok = 1'b0;
    @(negedge clk);
    b3.start = 1'b1; b3.filter_base = 16'h1230; b3.filter_length = 13'd20; b3.repeat_count = 8'd3;
    @(negedge clk); b3.start = 1'b0;
    for (int n = 0; n < 1500; n++) begin
      b3.filter_block = '0;
      if ($urandom_range(0, 1) == 1) b3.filter_block[$urandom_range(0, 219)] = 1'b1;
      #1;
      if (b3.done === 1'b1) begin ok = 1'b1; break; end
      @(negedge clk);
    end
    b3.filter_block = '0;
    checks++; if (!ok) begin errors++; $display("FAIL lat3_done_timeout: got done=0 want 1"); end
    checks++; if (dq3.size() - o0 != 60 || aq3.size() - a0 != 60) begin
      errors++; $display("FAIL lat3_count: got outs=%0d reads=%0d want 60 60", dq3.size() - o0, aq3.size() - a0); end
    for (int i = 0; i < 60 && o0 + i < dq3.size() && a0 + i < aq3.size(); i++) begin
      ea = 16'h1230 + 16'(i % 20);
      if (aq3[a0+i] !== ea || cq3[o0+i] !== 13'(i % 20) || pq3[o0+i] !== 8'(i / 20) || dq3[o0+i] !== mem_word(ea)) begin
        bad++;
        if (bad <= 4) $display("lat3 entry %0d: addr=%h cnt=%0d pass=%0d data=%h want %h %0d %0d %h",
                               i, aq3[a0+i], cq3[o0+i], pq3[o0+i], dq3[o0+i], ea, i % 20, i / 20, mem_word(ea));
      end
    end
    checks++; if (bad != 0) begin errors++; $display("FAIL lat3_order: got %0d bad entries want 0", bad); end
    checks++; if (viol3 != 0) begin errors++; $display("FAIL lat3_overflow: got %0d credit violations want 0", viol3); end
    checks++; if (blk3 != 0 || blk1 != 0) begin
      errors++; $display("FAIL valid_while_blocked: got %0d/%0d want 0/0", blk1, blk3); end
  endtask

  initial begin
    rst = 1'b1;
    b1.start = 1'b0; b1.filter_base = '0; b1.filter_length = '0; b1.repeat_count = '0; b1.filter_block = '0;
    b3.start = 1'b0; b3.filter_base = '0; b3.filter_length = '0; b3.repeat_count = '0; b3.filter_block = '0;
    test_reset();
    test_basic();
    test_backpressure();
    test_wrap();
    test_zero_len();
    test_stray_and_reset();
    test_latency3();
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
